// File: rtl/regs_pkg.sv
// Shared constants for the integer register file writeback path.
package regs_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam int SRC_EXU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  // One-hot register select; x0 never appears so it can never be marked busy.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[a] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_any;

  always_comb begin
    int idx;
    gnt        = '0;
    w_any      = 1'b0;
    w_next_ptr = r_ptr;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_any && req[idx]) begin
        gnt[idx]   = 1'b1;
        w_any      = 1'b1;
        w_next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/regs_wb_sched.sv
// Writeback scheduler and busy-register scoreboard driving the register
// file's single write port from several round-robin arbitrated sources.
module regs_wb_sched
  import regs_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int NUM_SRC  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             wb_valid,
  output logic [NUM_SRC-1:0]             wb_ready,
  input  logic [REG_ADDR_W*NUM_SRC-1:0]  wb_rd,
  input  logic [DATA_LEN*NUM_SRC-1:0]    wb_data,
  input  logic                           claim_valid,
  input  logic [REG_ADDR_W-1:0]          claim_rd,
  input  logic [REG_ADDR_W-1:0]          chk_rs1,
  input  logic [REG_ADDR_W-1:0]          chk_rs2,
  input  logic [REG_ADDR_W-1:0]          chk_rd,
  output logic                           hazard,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic                           dest_wen,
  output logic [REG_ADDR_W-1:0]          rd,
  output logic [DATA_LEN-1:0]            dest_data,
  output logic                           sb_err
);

  logic [NUM_SRC-1:0]    w_gnt;
  logic                  w_any_gnt;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [DATA_LEN-1:0]   w_sel_data;
  logic                  w_claim_hit;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  w_claim_err;
  logic                  w_wb_err;

  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_dest_wen;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_LEN-1:0]   r_dest_data;
  logic                  r_sb_err;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (wb_valid),
    .gnt (w_gnt)
  );

  assign wb_ready  = w_gnt;
  assign w_any_gnt = |w_gnt;

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) begin
        w_sel_rd   = wb_rd[i*REG_ADDR_W +: REG_ADDR_W];
        w_sel_data = wb_data[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign w_claim_hit = claim_valid && (claim_rd != '0);
  assign w_set       = w_claim_hit ? reg_onehot(claim_rd) : '0;
  assign w_clr       = r_dest_wen ? reg_onehot(r_rd) : '0;
  // Applying the set after the clear lets a same-edge re-claim win.
  assign w_busy_nxt  = (r_busy & ~w_clr) | w_set;

  assign w_claim_err = w_claim_hit && r_busy[claim_rd];
  assign w_wb_err    = w_any_gnt && (w_sel_rd != '0) && !r_busy[w_sel_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_dest_wen  <= 1'b0;
      r_rd        <= '0;
      r_dest_data <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_dest_wen <= w_any_gnt && (w_sel_rd != '0);
      if (w_any_gnt) begin
        r_rd        <= w_sel_rd;
        r_dest_data <= w_sel_data;
      end
      if (w_claim_err || w_wb_err) r_sb_err <= 1'b1;
    end
  end

  assign hazard    = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];
  assign busy_vec  = r_busy;
  assign dest_wen  = r_dest_wen;
  assign rd        = r_rd;
  assign dest_data = r_dest_data;
  assign sb_err    = r_sb_err;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Bench for regs_wb_sched: directed scenarios plus a per-cycle reference model.
module tb_regs_wb_sched;
  import regs_pkg::*;

  localparam int DL = 32;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] wb_valid;
  logic [NS-1:0] wb_ready;
  logic [5*NS-1:0]  wb_rd;
  logic [DL*NS-1:0] wb_data;
  logic          claim_valid;
  logic [4:0]    claim_rd;
  logic [4:0]    chk_rs1, chk_rs2, chk_rd;
  logic          hazard;
  logic [31:0]   busy_vec;
  logic          dest_wen;
  logic [4:0]    rd;
  logic [DL-1:0] dest_data;
  logic          sb_err;

  regs_wb_sched #(.DATA_LEN(DL), .NUM_SRC(NS)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .busy_vec(busy_vec),
    .dest_wen(dest_wen), .rd(rd), .dest_data(dest_data), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: busy set, last write port contents, error flag, pointer.
  logic [31:0]   m_busy;
  int            m_ptr;
  logic          m_wen;
  logic [4:0]    m_rd;
  logic [DL-1:0] m_data;
  logic          m_err;
  bit            m_live = 1'b0;

  // Winner = valid source with the smallest forward distance from the pointer.
  function automatic int model_gnt();
    int best, bestd, d;
    best  = -1;
    bestd = NS;
    for (int i = 0; i < NS; i++) begin
      d = (i - m_ptr + NS) % NS;
      if (wb_valid[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  int            mg;
  logic [4:0]    mg_rd;
  logic [DL-1:0] mg_data;
  logic [31:0]   mnb;
  logic          mne;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = '0; m_ptr = 0; m_wen = 0; m_rd = '0; m_data = '0; m_err = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      mg = model_gnt();
      mg_rd = '0; mg_data = '0;
      if (mg >= 0) begin
        mg_rd   = wb_rd[mg*5 +: 5];
        mg_data = wb_data[mg*DL +: DL];
      end
      mne = m_err;
      if (claim_valid && claim_rd != 0 && m_busy[claim_rd]) mne = 1'b1;
      if (mg >= 0 && mg_rd != 0 && !m_busy[mg_rd]) mne = 1'b1;
      mnb = m_busy;
      if (m_wen) mnb[m_rd] = 1'b0;
      if (claim_valid && claim_rd != 0) mnb[claim_rd] = 1'b1;
      m_busy = mnb;
      m_err  = mne;
      m_wen  = (mg >= 0) && (mg_rd != 0);
      if (mg >= 0) begin
        m_rd   = mg_rd;
        m_data = mg_data;
        m_ptr  = (mg + 1) % NS;
      end
    end
  end

  logic [NS-1:0] exp_rdy;
  always @(negedge clk) begin
    if (m_live) begin
      exp_rdy = '0;
      if (model_gnt() >= 0) exp_rdy[model_gnt()] = 1'b1;
      chk("m_wb_ready", 64'(wb_ready), 64'(exp_rdy));
      chk("m_busy_vec", 64'(busy_vec), 64'(m_busy));
      chk("m_hazard", 64'(hazard), 64'(m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]));
      chk("m_dest_wen", 64'(dest_wen), 64'(m_wen));
      if (m_wen) begin
        chk("m_rd", 64'(rd), 64'(m_rd));
        chk("m_dest_data", 64'(dest_data), 64'(m_data));
      end
      chk("m_sb_err", 64'(sb_err), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [NS-1:0] rr_exp [6];

  initial begin
    rst = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
    claim_valid = 1'b0; claim_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy_vec), 64'h0);
    chk("rst_wen", 64'(dest_wen), 64'h0);
    chk("rst_rd", 64'(rd), 64'h0);
    chk("rst_data", 64'(dest_data), 64'h0);
    chk("rst_err", 64'(sb_err), 64'h0);

    // Single LSU writeback to a claimed register
    claim_valid = 1'b1; claim_rd = 5'd5;
    step();
    claim_valid = 1'b0;
    chk("single_busy_set", 64'(busy_vec[5]), 64'h1);
    step();
    wb_valid = 3'b010; wb_rd[SRC_LSU*5 +: 5] = 5'd5; wb_data[SRC_LSU*DL +: DL] = 32'hDEADBEEF;
    #1 chk("single_ready", 64'(wb_ready), 64'(3'b010));
    step();
    wb_valid = '0;
    chk("single_wen", 64'(dest_wen), 64'h1);
    chk("single_rd", 64'(rd), 64'd5);
    chk("single_data", 64'(dest_data), 64'hDEADBEEF);
    step();
    chk("single_busy_clr", 64'(busy_vec[5]), 64'h0);
    chk("single_err", 64'(sb_err), 64'h0);

    // Round robin with all sources valid
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      claim_valid = 1'b1; claim_rd = 5'(r);
      step();
    end
    claim_valid = 1'b0;
    wb_valid = 3'b111;
    wb_rd = {5'd3, 5'd2, 5'd1};
    wb_data = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_order", 64'(wb_ready), 64'(rr_exp[c]));
      step();
    end
    wb_valid = '0;
    step();

    // Hazard window for x7, and x0 never busy
    do_reset();
    claim_valid = 1'b1; claim_rd = 5'd7;
    step();
    claim_valid = 1'b0; chk_rs2 = 5'd7;
    #1 chk("haz_after_claim", 64'(hazard), 64'h1);
    step();
    wb_valid = 3'b001; wb_rd[SRC_EXU*5 +: 5] = 5'd7; wb_data[SRC_EXU*DL +: DL] = 32'h00000777;
    #1 chk("haz_grant_cycle", 64'(hazard), 64'h1);
    step();
    wb_valid = '0;
    #1 chk("haz_wen_cycle", 64'(hazard), 64'h1);
    chk("haz_wen", 64'(dest_wen), 64'h1);
    step();
    #1 chk("haz_dropped", 64'(hazard), 64'h0);
    chk_rs2 = '0; chk_rs1 = '0;
    #1 chk("haz_x0", 64'(hazard), 64'h0);
    claim_valid = 1'b1; claim_rd = 5'd20;
    step();
    claim_valid = 1'b0; chk_rd = 5'd20;
    #1 chk("haz_chk_rd", 64'(hazard), 64'h1);
    chk_rd = '0;
    step();

    // Claim of x9 at the same edge it is written back
    do_reset();
    claim_valid = 1'b1; claim_rd = 5'd9;
    step();
    claim_valid = 1'b0;
    wb_valid = 3'b001; wb_rd[SRC_EXU*5 +: 5] = 5'd9; wb_data[SRC_EXU*DL +: DL] = 32'h99;
    step();
    wb_valid = '0;
    claim_valid = 1'b1; claim_rd = 5'd9;
    #1 chk("conf_wen_rd", 64'({dest_wen, rd}), 64'({1'b1, 5'd9}));
    step();
    claim_valid = 1'b0;
    chk("conf_busy9", 64'(busy_vec[9]), 64'h1);
    chk("conf_err", 64'(sb_err), 64'h1);
    do_reset();
    chk("conf_err_rst", 64'(sb_err), 64'h0);

    // x0 writeback, then unclaimed x12
    wb_valid = 3'b100; wb_rd[SRC_CSR*5 +: 5] = 5'd0; wb_data[SRC_CSR*DL +: DL] = 32'h12345678;
    #1 chk("x0_ready", 64'(wb_ready), 64'(3'b100));
    step();
    wb_rd[SRC_CSR*5 +: 5] = 5'd12; wb_data[SRC_CSR*DL +: DL] = 32'hC0DE0012;
    chk("x0_wen", 64'(dest_wen), 64'h0);
    chk("x0_err", 64'(sb_err), 64'h0);
    step();
    wb_valid = '0;
    chk("unclaimed_wen", 64'(dest_wen), 64'h1);
    chk("unclaimed_rd", 64'(rd), 64'd12);
    chk("unclaimed_data", 64'(dest_data), 64'hC0DE0012);
    chk("unclaimed_err", 64'(sb_err), 64'h1);
    step(); step();
    chk("unclaimed_err_sticky", 64'(sb_err), 64'h1);

    // Reset mid-stream with a grant pending
    do_reset();
    claim_valid = 1'b1; claim_rd = 5'd4;
    step();
    claim_valid = 1'b0;
    wb_valid = 3'b010; wb_rd[SRC_LSU*5 +: 5] = 5'd4; wb_data[SRC_LSU*DL +: DL] = 32'h44444444;
    rst = 1'b1;
    step();
    rst = 1'b0; wb_valid = '0;
    chk("mid_rst_wen", 64'(dest_wen), 64'h0);
    chk("mid_rst_busy", 64'(busy_vec), 64'h0);
    chk("mid_rst_err", 64'(sb_err), 64'h0);
    chk("mid_rst_rd_data", 64'({rd, dest_data}), 64'h0);
    step();
    chk("mid_rst_no_pulse", 64'(dest_wen), 64'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
